// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-stage enables/clears for load-use stalls,
// branch squash, data-RAM wait states and exception flush/redirect.
module pipeline_hazard_ctrl #(
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_useRs,
    input  logic        id_useRt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_registerWriteAddress,
    input  logic        branch_taken,
    input  logic        except_req,
    input  logic [31:0] mem_pc,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        id_clear,
    output logic        ex_clear,
    output logic        mem_clear,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        bus_error,
    output logic [31:0] stall_cycles,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        MEM_WAIT     = 2'd1,
        EXC_FLUSH    = 2'd2,
        EXC_REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       capture_epc;
    logic       wait_load;

    assign load_use = ex_memRead && (ex_registerWriteAddress != 5'd0) &&
                      ((id_useRs && (id_rs == ex_registerWriteAddress)) ||
                       (id_useRt && (id_rt == ex_registerWriteAddress)));

    assign dbg_state = state;

    // Outputs are decoded combinationally; priority is rst > !cpu_en > state/inputs.
    always_comb begin
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        mem_en      = 1'b1;
        id_clear    = 1'b0;
        ex_clear    = 1'b0;
        mem_clear   = 1'b0;
        redirect    = 1'b0;
        bus_error   = 1'b0;
        capture_epc = 1'b0;
        wait_load   = 1'b0;
        state_nxt   = state;
        if (rst) begin
            {if_en, id_en, ex_en, mem_en} = 4'b0000;
            {id_clear, ex_clear, mem_clear} = 3'b111;
            state_nxt = RUN;
        end else if (!cpu_en) begin
            {if_en, id_en, ex_en, mem_en} = 4'b0000;
        end else begin
            case (state)
                RUN: begin
                    if (except_req) begin
                        {id_clear, ex_clear, mem_clear} = 3'b111;
                        capture_epc = 1'b1;
                        state_nxt   = EXC_FLUSH;
                    end else if (mem_req && !mem_ready) begin
                        {if_en, id_en, ex_en, mem_en} = 4'b0000;
                        wait_load = 1'b1;
                        state_nxt = MEM_WAIT;
                    end else if (load_use) begin
                        // Branch is deliberately ignored; it is re-evaluated once the stall clears.
                        if_en    = 1'b0;
                        id_en    = 1'b0;
                        ex_clear = 1'b1;
                    end else if (branch_taken) begin
                        id_clear = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    {if_en, id_en, ex_en, mem_en} = 4'b0000;
                    if (mem_ready) begin
                        {if_en, id_en, ex_en, mem_en} = 4'b1111;
                        state_nxt = RUN;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        bus_error   = 1'b1;
                        capture_epc = 1'b1;
                        state_nxt   = EXC_FLUSH;
                    end
                end
                EXC_FLUSH: begin
                    {id_clear, ex_clear, mem_clear} = 3'b111;
                    state_nxt = EXC_REDIRECT;
                end
                EXC_REDIRECT: begin
                    redirect  = 1'b1;
                    id_clear  = 1'b1;
                    state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            epc          <= 32'd0;
            stall_cycles <= 32'd0;
            wait_cnt     <= 8'd0;
            redirect_pc  <= EXC_VECTOR;
        end else if (cpu_en) begin
            state <= state_nxt;
            if (capture_epc)
                epc <= mem_pc;
            if (wait_load)
                wait_cnt <= 8'd1;
            else if (state == MEM_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (!if_en && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (state_nxt == EXC_REDIRECT)
                redirect_pc <= EXC_VECTOR;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates per-stage enable and clear signals for load-use stalls, taken-branch squash, data-RAM wait states and exception flush/redirect. Its mem_clear output drives the exception-clear input of the EX/MEM register; the *_en outputs feed each pipeline register's enable input. It also maintains a saturating stall-cycle counter for debug.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before a bus error is raised (range 1..255)
EXC_VECTOR, 32'h0000_0008, PC loaded on exception redirect

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_en  in  1  global run enable; 0 freezes the whole pipeline
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_useRs  in  1  ID instruction reads rs
id_useRt  in  1  ID instruction reads rt
ex_memRead  in  1  instruction in EX is a load
ex_registerWriteAddress  in  5  destination register of the instruction in EX
branch_taken  in  1  branch or jump resolved taken in ID this cycle
except_req  in  1  exception detected by the instruction in MEM
mem_pc  in  32  PC of the instruction in MEM
mem_req  in  1  MEM stage is accessing the data RAM this cycle
mem_ready  in  1  data RAM access completes this cycle
if_en  out  1  PC / IF/ID enable
id_en  out  1  ID/EX enable
ex_en  out  1  EX/MEM enable
mem_en  out  1  MEM/WB enable
id_clear  out  1  squash IF/ID contents
ex_clear  out  1  insert bubble into ID/EX
mem_clear  out  1  squash EX/MEM contents (exception clear)
redirect  out  1  one-cycle pulse: load redirect_pc into the PC
redirect_pc  out  32  target PC for redirect
epc  out  32  latched PC of the excepting instruction
bus_error  out  1  one-cycle pulse on data-RAM timeout
stall_cycles  out  32  saturating count of cycles in which if_en=0 while cpu_en=1

Behaviour:
- States: RUN, MEM_WAIT, EXC_FLUSH, EXC_REDIRECT. State register is clocked; outputs are combinational from state and inputs, except epc, stall_cycles, the wait counter and redirect_pc, which are registered.
- While rst=1: state<=RUN; epc, stall_cycles, wait counter <=0. Outputs: all *_en=0, all *_clear=1, redirect=0, bus_error=0, redirect_pc=EXC_VECTOR.
- cpu_en=0, any state: all *_en=0, all *_clear=0, redirect=0. State, counters and epc hold.
- Priority within a cycle: rst > !cpu_en > except_req > memory wait > load-use > branch_taken.
- load_use = ex_memRead & (ex_registerWriteAddress!=0) & ((id_useRs & id_rs==ex_registerWriteAddress) | (id_useRt & id_rt==ex_registerWriteAddress)).
- RUN defaults: all en=1, all clear=0.
  - except_req: epc<=mem_pc; id_clear=ex_clear=mem_clear=1; all en=1; next state EXC_FLUSH.
  - else if mem_req & !mem_ready: all en=0; wait counter<=1; next state MEM_WAIT.
  - else if load_use: if_en=id_en=0; ex_clear=1; ex_en=mem_en=1. branch_taken is ignored this cycle and re-evaluated next cycle.
  - else if branch_taken: id_clear=1 only.
- MEM_WAIT: all en=0, all clear=0; counter increments each cycle.
  - mem_ready: all en=1; next state RUN.
  - counter==MEM_TIMEOUT without mem_ready: bus_error=1; epc<=mem_pc; next state EXC_FLUSH.
  - except_req is ignored in this state.
- EXC_FLUSH: id_clear=ex_clear=mem_clear=1, all en=1; next state EXC_REDIRECT.
- EXC_REDIRECT: redirect=1, redirect_pc=EXC_VECTOR, id_clear=1, all en=1; next state RUN.
- stall_cycles increments when cpu_en=1, rst=0 and if_en=0, and saturates at 32'hFFFF_FFFF.

Test Plan:
- Load-use: ex_memRead=1, ex_registerWriteAddress=5, id_rs=5, id_useRs=1 for 1 cycle -> if_en=id_en=0, ex_clear=1, ex_en=1, stall_cycles=1; same case with register 0 -> no stall.
- Branch squash: branch_taken=1 in RUN -> id_clear=1 for exactly 1 cycle, all en=1; branch_taken together with load_use -> stall only, no id_clear.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> all en=0 for 3 cycles, all en=1 on the ready cycle, then RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 -> bus_error pulses on the 4th MEM_WAIT cycle, epc=mem_pc, then EXC_FLUSH followed by EXC_REDIRECT with redirect_pc=32'h8.
- Exception: except_req=1 with mem_pc=32'h40 -> mem_clear=1 on that cycle and the next, redirect=1 two cycles later, epc=32'h40.
- Freeze/reset: cpu_en=0 during MEM_WAIT -> counter and state hold; rst=1 mid-EXC_FLUSH -> next cycle RUN, redirect=0, stall_cycles=0.
